// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode.
// DEPTH-entry circular buffer of {pc, instr} with valid/ready on both sides
// and a single-cycle flush for branch redirects.
// Optional build macro: FETCH_QUEUE_BYPASS_EN (empty-queue pass-through).
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INSN_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSN_W-1:0]        in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSN_W-1:0]        out_instr,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. Producers hold data stable while valid is high and not ready.
    // in_ready never looks at out_ready, so decode stalls never reach fetch
    // combinationally.

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       rd_ptr;
    logic [AW:0]       wr_ptr;
    logic [PC_W-1:0]   mem_pc    [DEPTH];
    logic [INSN_W-1:0] mem_instr [DEPTH];

    logic empty;
    logic full;
    logic enq_fire;
    logic deq_fire;
    logic store_en;
    logic pop_en;

    assign empty    = (rd_ptr == wr_ptr);
    assign full     = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign count    = wr_ptr - rd_ptr;
    assign in_ready = ~full & ~flush;
    assign enq_fire = in_valid & in_ready;
    assign deq_fire = out_valid & out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with decode ready: hand the fetched entry straight over
    // without touching storage.
    logic bypass_hit;
    assign bypass_hit = empty & ~flush & in_valid & out_ready;
    assign out_valid  = (~empty & ~flush) | bypass_hit;
    assign out_pc     = bypass_hit ? in_pc    : mem_pc[rd_ptr[AW-1:0]];
    assign out_instr  = bypass_hit ? in_instr : mem_instr[rd_ptr[AW-1:0]];
    assign store_en   = enq_fire & ~bypass_hit;
    assign pop_en     = deq_fire & ~bypass_hit;
`else
    // Outputs come only from storage; stale head is visible while invalid.
    assign out_valid  = ~empty & ~flush;
    assign out_pc     = mem_pc[rd_ptr[AW-1:0]];
    assign out_instr  = mem_instr[rd_ptr[AW-1:0]];
    assign store_en   = enq_fire;
    assign pop_en     = deq_fire;
`endif

    // Storage write; contents are deliberately not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem_pc[wr_ptr[AW-1:0]]    <= in_pc;
            mem_instr[wr_ptr[AW-1:0]] <= in_instr;
        end
    end

    // Pointer update: reset dominates flush; flush empties by catching rd up to wr.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (store_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_en)   rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a queue-based
// reference model compared every cycle, plus literal spot checks.
// Honours FETCH_QUEUE_BYPASS_EN when the design is built with it.
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 64;
    localparam int INSN_W = 32;
    localparam int W      = PC_W + INSN_W;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INSN_W-1:0] in_instr;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INSN_W-1:0] out_instr;
    logic              out_ready;
    logic              flush;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    exp_q[$];
    logic [PC_W-1:0] got_q[$];

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSN_W(INSN_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
        .flush(flush), .count(count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSN_W-1:0] instr_of(input logic [PC_W-1:0] pc);
        return pc[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        #3;
    endtask

    // reference model: a plain FIFO of entries, advanced on each rising edge
    int   m_n;
    logic m_byp;
    always @(posedge clk) begin
        m_n = exp_q.size();
`ifdef FETCH_QUEUE_BYPASS_EN
        m_byp = (m_n == 0) && !flush && in_valid && out_ready;
`else
        m_byp = 1'b0;
`endif
        if (reset) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else if (!m_byp) begin
            if (m_n > 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && m_n < DEPTH) exp_q.push_back({in_pc, instr_of(in_pc)});
        end
    end

    // scoreboard compare: outputs against model every cycle, on the falling edge
    logic          e_valid;
    logic          e_ready;
    logic [W-1:0]  e_head;
    always @(negedge clk) begin
        if (!reset) begin
            e_ready = (exp_q.size() < DEPTH) && !flush;
            e_valid = (exp_q.size() > 0) && !flush;
            e_head  = (exp_q.size() > 0) ? exp_q[0] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
            if (exp_q.size() == 0 && !flush && in_valid && out_ready) begin
                e_valid = 1'b1;
                e_head  = {in_pc, instr_of(in_pc)};
            end
`endif
            check("sb_in_ready", 64'(in_ready), 64'(e_ready));
            check("sb_out_valid", 64'(out_valid), 64'(e_valid));
            check("sb_count", 64'(count), 64'(exp_q.size()));
            if (e_valid) begin
                check("sb_out_pc", out_pc, e_head[W-1:INSN_W]);
                check("sb_out_instr", 64'(out_instr), 64'(e_head[INSN_W-1:0]));
            end
            if (out_valid && out_ready) got_q.push_back(out_pc);
        end
    end

    logic [PC_W-1:0] base;

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        reset = 1'b0;

        // 1: reset state
        mid_cycle();
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 2: fill without draining, fifth offer refused, then drain in order
        base = 64'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, base + 64'(4 * i), 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b1, base + 64'h10, 1'b0, 1'b0);
        mid_cycle();
        check("fill_count", 64'(count), 64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        next_cycle();
        got_q.delete();
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) next_cycle();
        check("drain_n", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            check("drain_0", got_q[0], 64'h8000_0000);
            check("drain_1", got_q[1], 64'h8000_0004);
            check("drain_2", got_q[2], 64'h8000_0008);
            check("drain_3", got_q[3], 64'h8000_000C);
        end

        // 3: steady enqueue+dequeue at count 2
        base = 64'h8000_1000;
        drive(1'b1, base, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, base + 64'h4, 1'b0, 1'b0);
        next_cycle();
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, base + 64'(8 + 4 * i), 1'b1, 1'b0);
            mid_cycle();
            check("steady_count", 64'(count), 64'd2);
            next_cycle();
        end
        check("steady_n", 64'(got_q.size()), 64'd10);
        if (got_q.size() == 10) begin
            check("steady_first", got_q[0], 64'h8000_1000);
            for (int i = 1; i < 10; i++) check("steady_step", got_q[i] - got_q[i-1], 64'd4);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) next_cycle();

        // 4: flush with 3 held and a same-cycle offer
        base = 64'h8000_2000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, base + 64'(4 * i), 1'b0, 1'b0);
            next_cycle();
        end
        drive(1'b1, 64'h8000_0200, 1'b1, 1'b1);
        mid_cycle();
        check("flush_in_ready", 64'(in_ready), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        next_cycle();
        drive(1'b1, 64'h8000_0100, 1'b0, 1'b0);
        mid_cycle();
        check("post_flush_count", 64'(count), 64'd0);
        check("post_flush_valid", 64'(out_valid), 64'd0);
        check("post_flush_ready", 64'(in_ready), 64'd1);
        next_cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        mid_cycle();
        check("post_flush_head_v", 64'(out_valid), 64'd1);
        check("post_flush_head", out_pc, 64'h8000_0100);
        next_cycle();
        next_cycle();

        // 5: reset mid-stream
        drive(1'b1, 64'h8000_3000, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 64'h8000_3004, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 64'h8000_3008, 1'b0, 1'b0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(1'b1, 64'h8000_3100, 1'b0, 1'b0);
        mid_cycle();
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        next_cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        mid_cycle();
        check("mid_rst_head", out_pc, 64'h8000_3100);
        next_cycle();
        next_cycle();

        // 6: empty queue, offer with decode ready
        drive(1'b1, 64'h8000_0040, 1'b1, 1'b0);
        mid_cycle();
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid", 64'(out_valid), 64'd1);
        check("byp_pc", out_pc, 64'h8000_0040);
        check("byp_count", 64'(count), 64'd0);
        next_cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        mid_cycle();
        check("byp_after_valid", 64'(out_valid), 64'd0);
        check("byp_after_count", 64'(count), 64'd0);
`else
        check("nobyp_valid", 64'(out_valid), 64'd0);
        next_cycle();
        drive(1'b0, '0, 1'b1, 1'b0);
        mid_cycle();
        check("nobyp_next_valid", 64'(out_valid), 64'd1);
        check("nobyp_next_pc", out_pc, 64'h8000_0040);
`endif
        next_cycle();
        next_cycle();

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
